// File: rtl/instr_exec_core_if.sv
// Memory request bus between the PDP-8 execute unit (master) and memory_pdp (slave).
// Single-word read/write strobes; read data returns the cycle after exec_rd_req.
interface instr_exec_core_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 12
);
  logic          exec_rd_req;
  logic [AW-1:0] exec_rd_addr;
  logic [DW-1:0] exec_rd_data;
  logic          exec_wr_req;
  logic [AW-1:0] exec_wr_addr;
  logic [DW-1:0] exec_wr_data;

  modport master (
    output exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
    input  exec_rd_data
  );

  modport slave (
    input  exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
    output exec_rd_data
  );
endinterface

// File: rtl/instr_exec_core.sv
// PDP-8 execute unit: owns AC, Link and PC, executes decoded memory-reference and
// group-1 OP7 instructions, and paces the decoder through stall/PC_value.
package instr_exec_core_pkg;
  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DATA_WIDTH = 12;

  typedef struct packed {
    logic                  NOP;
    logic                  AND;
    logic                  TAD;
    logic                  ISZ;
    logic                  DCA;
    logic                  JMS;
    logic                  JMP;
    logic [ADDR_WIDTH-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA1;
    logic CLA_CLL;
    logic HLT;
    logic OSR;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
    logic CLA2;
  } pdp_op7_opcode_s;
endpackage

module instr_exec_core
  import instr_exec_core_pkg::*;
#(
  parameter int unsigned           DECODE_LAT = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  pdp_mem_opcode_s       pdp_mem_opcode,
  input  pdp_op7_opcode_s       pdp_op7_opcode,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] PC_value,
  instr_exec_core_if.master     mem_bus,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  link,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_INIT, S_ISSUE, S_EXEC, S_MEM_WAIT, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_AND, OP_TAD, OP_ISZ, OP_DCA, OP_JMS, OP_JMP, OP_OP7
  } op_t;

  typedef struct packed {
    logic cla;
    logic cll;
    logic cma;
    logic cml;
    logic iac;
    logic rar;
    logic ral;
    logic hlt;
  } micro_t;

  localparam int unsigned CW = (DECODE_LAT > 1) ? $clog2(DECODE_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECODE_LAT - 1);

  state_t                state;
  op_t                   op_d, op_q;
  micro_t                micro_d, micro_q;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] ea_q;
  logic [DATA_WIDTH:0]   op7_lac;
  logic [DATA_WIDTH:0]   tad_sum;
  logic                  op7_unused;

  always_comb begin
    micro_d = '{cla: pdp_op7_opcode.CLA1, cll: pdp_op7_opcode.CLL,
                cma: pdp_op7_opcode.CMA,  cml: pdp_op7_opcode.CML,
                iac: pdp_op7_opcode.IAC,  rar: pdp_op7_opcode.RAR,
                ral: pdp_op7_opcode.RAL,  hlt: pdp_op7_opcode.HLT};
    op7_unused = ^{pdp_op7_opcode.NOP, pdp_op7_opcode.RTL, pdp_op7_opcode.RTR,
                   pdp_op7_opcode.CIA, pdp_op7_opcode.CLA_CLL, pdp_op7_opcode.OSR,
                   pdp_op7_opcode.SKP, pdp_op7_opcode.SNL, pdp_op7_opcode.SZL,
                   pdp_op7_opcode.SZA, pdp_op7_opcode.SNA, pdp_op7_opcode.SMA,
                   pdp_op7_opcode.SPA, pdp_op7_opcode.CLA2};
  end

  // Any memory flag (including NOP) takes precedence over the OP7 struct.
  always_comb begin
    op_d = OP_NOP;
    if      (pdp_mem_opcode.AND) op_d = OP_AND;
    else if (pdp_mem_opcode.TAD) op_d = OP_TAD;
    else if (pdp_mem_opcode.ISZ) op_d = OP_ISZ;
    else if (pdp_mem_opcode.DCA) op_d = OP_DCA;
    else if (pdp_mem_opcode.JMS) op_d = OP_JMS;
    else if (pdp_mem_opcode.JMP) op_d = OP_JMP;
    else if (pdp_mem_opcode.NOP) op_d = OP_NOP;
    else if (|micro_d)           op_d = OP_OP7;
  end

  // 13-bit {L,AC} datapath: a +1 carry out of AC bit 11 naturally toggles L.
  always_comb begin
    op7_lac = {link, acc};
    if (micro_q.cla) op7_lac[DATA_WIDTH-1:0] = '0;
    if (micro_q.cll) op7_lac[DATA_WIDTH]     = 1'b0;
    if (micro_q.cma) op7_lac[DATA_WIDTH-1:0] = ~op7_lac[DATA_WIDTH-1:0];
    if (micro_q.cml) op7_lac[DATA_WIDTH]     = ~op7_lac[DATA_WIDTH];
    if (micro_q.iac) op7_lac = op7_lac + 13'd1;
    if (micro_q.rar && !micro_q.ral)
      op7_lac = {op7_lac[0], op7_lac[DATA_WIDTH:1]};
    else if (micro_q.ral && !micro_q.rar)
      op7_lac = {op7_lac[DATA_WIDTH-1:0], op7_lac[DATA_WIDTH]};
    tad_sum = {1'b0, acc} + {1'b0, mem_bus.exec_rd_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_INIT;
      stall                <= 1'b1;
      PC_value             <= START_ADDR;
      acc                  <= '0;
      link                 <= 1'b0;
      halted               <= 1'b0;
      cnt                  <= '0;
      op_q                 <= OP_NOP;
      micro_q              <= '0;
      ea_q                 <= '0;
      mem_bus.exec_rd_req  <= 1'b0;
      mem_bus.exec_rd_addr <= '0;
      mem_bus.exec_wr_req  <= 1'b0;
      mem_bus.exec_wr_addr <= '0;
      mem_bus.exec_wr_data <= '0;
    end else begin
      mem_bus.exec_rd_req <= 1'b0;
      mem_bus.exec_wr_req <= 1'b0;
      case (state)
        S_INIT: begin
          PC_value <= base_addr;
          stall    <= 1'b0;
          cnt      <= '0;
          state    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            op_q    <= op_d;
            micro_q <= micro_d;
            ea_q    <= pdp_mem_opcode.mem_inst_addr;
            stall   <= 1'b1;
            state   <= S_EXEC;
            // Strobes are registered here so they are high during the EXEC cycle.
            case (op_d)
              OP_AND, OP_TAD, OP_ISZ: begin
                mem_bus.exec_rd_req  <= 1'b1;
                mem_bus.exec_rd_addr <= pdp_mem_opcode.mem_inst_addr;
              end
              OP_DCA: begin
                mem_bus.exec_wr_req  <= 1'b1;
                mem_bus.exec_wr_addr <= pdp_mem_opcode.mem_inst_addr;
                mem_bus.exec_wr_data <= acc;
              end
              OP_JMS: begin
                mem_bus.exec_wr_req  <= 1'b1;
                mem_bus.exec_wr_addr <= pdp_mem_opcode.mem_inst_addr;
                mem_bus.exec_wr_data <= PC_value + 12'd1;
              end
              default: ;
            endcase
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EXEC: begin
          stall <= 1'b0;
          state <= S_ISSUE;
          case (op_q)
            OP_AND, OP_TAD, OP_ISZ: begin
              stall <= 1'b1;
              state <= S_MEM_WAIT;
            end
            OP_DCA: begin
              acc      <= '0;
              PC_value <= PC_value + 12'd1;
            end
            OP_JMS: PC_value <= ea_q + 12'd1;
            OP_JMP: PC_value <= ea_q;
            OP_OP7: begin
              {link, acc} <= op7_lac;
              PC_value    <= PC_value + 12'd1;
              if (micro_q.hlt) begin
                stall  <= 1'b1;
                halted <= 1'b1;
                state  <= S_HALT;
              end
            end
            default: PC_value <= PC_value + 12'd1;
          endcase
        end
        S_MEM_WAIT: begin
          stall <= 1'b0;
          state <= S_ISSUE;
          case (op_q)
            OP_AND: begin
              acc      <= acc & mem_bus.exec_rd_data;
              PC_value <= PC_value + 12'd1;
            end
            OP_TAD: begin
              acc      <= tad_sum[DATA_WIDTH-1:0];
              link     <= link ^ tad_sum[DATA_WIDTH];
              PC_value <= PC_value + 12'd1;
            end
            OP_ISZ: begin
              stall                <= 1'b1;
              state                <= S_WRITEBACK;
              mem_bus.exec_wr_req  <= 1'b1;
              mem_bus.exec_wr_addr <= ea_q;
              mem_bus.exec_wr_data <= mem_bus.exec_rd_data + 12'd1;
            end
            default: PC_value <= PC_value + 12'd1;
          endcase
        end
        S_WRITEBACK: begin
          PC_value <= PC_value + ((mem_bus.exec_wr_data == '0) ? 12'd2 : 12'd1);
          stall    <= 1'b0;
          state    <= S_ISSUE;
        end
        S_HALT: ;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: doc/instr_exec_core.md
Name: instr_exec_core

Overview:
- Synthesizable PDP-8 execute unit, directly downstream of instr_decode.
- Consumes the decoded memory-reference and group-1 OP7 opcodes.
- Owns AC, Link and the Program Counter, and drives stall/PC_value back to the decoder.
- Issues single-word read and write requests to memory_pdp.

Parameters:
- DECODE_LAT, 4: cycles from stall falling to the cycle in which the opcode structs are sampled.
- START_ADDR, 12'o200: PC_value value during and right after reset.

Ports:
- clk  in  1  free-running clock.
- reset_n  in  1  reset; asynchronous and active-low.
- base_addr  in  `ADDR_WIDTH  first-instruction address from instr_decode.
- pdp_mem_opcode  in  pdp_mem_opcode_s  decoded memory instruction. Fields used: NOP, AND, TAD, ISZ, DCA, JMS, JMP, mem_inst_addr (final effective address; indirection already resolved by the decoder).
- pdp_op7_opcode  in  pdp_op7_opcode_s  decoded OP7. Fields used: CLA1, CLL, CMA, CML, IAC, RAR, RAL, HLT. All other fields are executed as NOP.
- stall  out  1  1 = busy; 0 = PC_value valid, decoder may fetch.
- PC_value  out  `ADDR_WIDTH  current PC.
- exec_rd_req  out  1  memory read strobe, 1 cycle.
- exec_rd_addr  out  `ADDR_WIDTH  read address.
- exec_rd_data  in  `DATA_WIDTH  read data, valid the cycle after exec_rd_req.
- exec_wr_req  out  1  memory write strobe, 1 cycle.
- exec_wr_addr  out  `ADDR_WIDTH  write address.
- exec_wr_data  out  `DATA_WIDTH  write data.
- acc  out  `DATA_WIDTH  AC (debug/checker).
- link  out  1  Link (debug/checker).
- halted  out  1  HLT executed.

Behaviour:
- Reset (async, any state):
  - stall=1, PC_value=START_ADDR, AC=0, L=0, halted=0.
  - All request strobes 0 and all address/data outputs 0.
  - FSM goes to INIT.
- INIT: one cycle; PC_value<=base_addr; go to ISSUE.
- ISSUE:
  - stall=0; an internal counter counts DECODE_LAT cycles.
  - On the final count, both structs are latched, stall<=1, and the FSM moves to EXEC.
  - If no used flag is set in either struct at that point, the instruction is a NOP.
- EXEC, one cycle, dispatch:
  - AND/TAD/ISZ: exec_rd_req=1, exec_rd_addr=ea; go to MEM_WAIT.
  - DCA: write AC to ea; AC<=0; PC+1; go to ISSUE.
  - JMS: write PC_value+1 to ea; PC<=ea+1; go to ISSUE.
  - JMP: PC<=ea; go to ISSUE.
  - OP7: apply micro-ops in fixed order:
    1. CLA1 (AC=0) and CLL (L=0).
    2. CMA (AC=~AC) and CML (L=~L).
    3. IAC: {L,AC}+1, with carry out of bit 11 complementing L.
    4. RAR/RAL: 13-bit rotate of {L,AC} by one. If both are set, no rotate.
    - Then PC+1. If HLT is set, go to HALT after the update; otherwise go to ISSUE.
  - NOP: PC+1; go to ISSUE.
- MEM_WAIT: capture exec_rd_data as M.
  - AND: AC<=AC&M; PC+1.
  - TAD: 13-bit sum {0,AC}+{0,M}; AC<=sum[11:0]; L<=L^sum[12]; PC+1.
  - ISZ: go to WRITEBACK with M+1 (mod 4096).
- WRITEBACK (ISZ only): write M+1 to ea; PC+2 if the result is 0, else PC+1; go to ISSUE.
- HALT: stall=1, halted=1, no requests. Exit only by reset.
- Arithmetic:
  - All PC arithmetic is modulo 4096 (12'o7777+1 = 0; 12'o7777+2 = 1).
  - AC arithmetic is modulo 4096, with carry routed to L as above.
- Simultaneous flags:
  - If a memory flag and OP7 flags are both set, the memory struct wins.
  - If several memory flags are set, priority is AND>TAD>ISZ>DCA>JMS>JMP.
- Strobe rules:
  - exec_rd_req and exec_wr_req are never high in the same cycle.
  - Each strobe is high for exactly one cycle per access.
- PC_value changes only in the cycle the FSM leaves EXEC, MEM_WAIT or WRITEBACK toward ISSUE, or in INIT. It is stable throughout ISSUE.
- Latency:
  - JMP/DCA/JMS/OP7/NOP take 1 cycle of stall.
  - AND/TAD take 2 cycles.
  - ISZ takes 3 cycles.
- Reset mid-operation: any pending strobe is dropped immediately (async). No partial write may complete after reset_n falls.

Test Plan:
- Reset then base_addr=12'o200:
  - stall=1 during reset; PC_value=12'o200.
  - stall falls 1 cycle after release; opcode sampled DECODE_LAT=4 cycles later.
- TAD chain: AC=0, M[12'o300]=12'o7777, TAD 300 twice:
  - after 1st: AC=7777, L=0; after 2nd: AC=7776, L=1.
  - PC advances 200→201→202.
- ISZ on M[12'o310]=12'o7777 at PC=12'o205:
  - write of 0 to 310 occurs; PC=12'o207.
  - Repeat with M=5: write 6; PC advances by 1.
- JMS 12'o400 at PC=12'o210: exec_wr_addr=400, exec_wr_data=12'o211, PC=12'o401. Then JMP 12'o200: PC=12'o200.
- OP7 sequence:
  - CLA CLL CMA IAC from any state: AC=0, L=1.
  - RAL on AC=12'o4000, L=0: AC=0, L=1.
  - Then DCA 320: writes 0, AC=0.
- HLT issued, then random opcodes: stall stays 1, halted=1, no strobes, PC frozen. Assert reset_n=0 mid-HALT: outputs return to reset values asynchronously.
